// File: rtl/qc_ldpc_syndrome_checker.sv
// QC-LDPC syndrome checker: streams hard-decision bits and accumulates
// H*c over two block rows using per-block rotating circulant columns.
module qc_ldpc_syndrome_checker #(
  parameter int CIRC  = 16,
  parameter int N_BLK = 4,
  localparam int BW   = (N_BLK > 1) ? $clog2(N_BLK) : 1,
  localparam int CW   = (CIRC > 1) ? $clog2(CIRC) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic [BW-1:0]     h_blk_idx,
  input  logic [2*CIRC-1:0] h_col,
  output logic [2*CIRC-1:0] syndrome,
  output logic              syn_valid,
  output logic              syn_zero,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ACCUM,
    DONE
  } state_t;

  localparam logic [CW-1:0] BIT_LAST = CW'(CIRC - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(N_BLK - 1);

  state_t              state;
  logic [2*CIRC-1:0]   col;
  logic [2*CIRC-1:0]   col_rot;
  logic [CW-1:0]       bit_cnt;
  logic [BW-1:0]       blk_cnt;
  logic                accept;

  // Each block-row half rotates right on its own.
  assign col_rot = {col[CIRC], col[2*CIRC-1:CIRC+1],
                    col[0], col[CIRC-1:1]};

  assign in_ready  = (state == ACCUM);
  assign busy      = (state != IDLE);
  assign accept    = in_ready & in_valid;
  assign h_blk_idx = blk_cnt;
  assign syn_zero  = ~|syndrome;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      syndrome  <= '0;
      col       <= '0;
      bit_cnt   <= '0;
      blk_cnt   <= '0;
      syn_valid <= 1'b0;
    end else begin
      syn_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            syndrome <= '0;
            bit_cnt  <= '0;
            blk_cnt  <= '0;
          end
        end
        LOAD: begin
          col   <= h_col;
          state <= ACCUM;
        end
        ACCUM: begin
          if (accept) begin
            if (in_bit) syndrome <= syndrome ^ col;
            col <= col_rot;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (blk_cnt == BLK_LAST) begin
                state     <= DONE;
                syn_valid <= 1'b1;
              end else begin
                blk_cnt <= blk_cnt + BW'(1);
                state   <= LOAD;
              end
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qc_ldpc_syndrome_checker.sv
// Randomized self-checking bench for qc_ldpc_syndrome_checker against
// a direct H*c reference computed from rotated circulant columns.
module tb_qc_ldpc_syndrome_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_bit;
  logic        in_ready;
  logic [1:0]  h_blk_idx;
  logic [31:0] h_col;
  logic [31:0] syndrome;
  logic        syn_valid;
  logic        syn_zero;
  logic        busy;

  logic [31:0] hmat [4];

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign h_col = hmat[h_blk_idx];

  qc_ldpc_syndrome_checker #(.CIRC(16), .N_BLK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .h_blk_idx (h_blk_idx),
    .h_col     (h_col),
    .syndrome  (syndrome),
    .syn_valid (syn_valid),
    .syn_zero  (syn_zero),
    .busy      (busy)
  );

  function automatic logic [15:0] rotr16(input int x, input int j);
    int y;
    y = ((x >> j) | (x << (16 - j))) & 'hffff;
    return y[15:0];
  endfunction

  // Syndrome = XOR of H columns selected by the 1-bits of the codeword.
  function automatic logic [31:0] ref_syn(input logic [63:0] cw);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 64; i++) begin
      if (cw[i]) begin
        int b;
        int j;
        int hi;
        int lo;
        b  = i / 16;
        j  = i % 16;
        hi = int'(hmat[b][31:16]);
        lo = int'(hmat[b][15:0]);
        s  = s ^ {rotr16(hi, j), rotr16(lo, j)};
      end
    end
    return s;
  endfunction

  task automatic rand_h();
    for (int b = 0; b < 4; b++) hmat[b] = $urandom;
  endtask

  task automatic run_cw(input logic [63:0] cw, input int duty,
                        input bit poke,
                        output logic [31:0] syn, output logic zero,
                        output int lat, output int early,
                        output int busy_bad);
    int  idx;
    int  n;
    bit  done;
    bit  acc;
    idx = 0; n = 0; done = 0;
    early = 0; busy_bad = 0; lat = -1;
    syn = 'x; zero = 'x;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 2000) begin
      if (syn_valid) begin
        done = 1;
        syn  = syndrome;
        zero = syn_zero;
        lat  = n;
        if (idx != 64) early = 1;
      end else begin
        if (!busy) busy_bad++;
        in_valid = (idx < 64) && ($urandom_range(99) < duty);
        in_bit   = in_valid ? cw[idx] : 1'b0;
        start    = poke && ($urandom_range(3) == 0);
        acc      = in_valid && in_ready;
        @(posedge clk);
        if (acc) idx++;
        @(negedge clk);
        n++;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b0 || syn_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rdy=%b sv=%b busy=%b want 0 0 0",
               in_ready, syn_valid, busy);
    end
    vectors++;
    if (h_blk_idx !== 2'd0 || syndrome !== 32'h0 || syn_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_data: got idx=%0d syn=%h z=%b want 0 0 1",
               h_blk_idx, syndrome, syn_zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_all_zero();
    logic [31:0] s;
    logic        z;
    int          lat, early, bb;
    rand_h();
    run_cw(64'h0, 100, 0, s, z, lat, early, bb);
    vectors++;
    if (lat !== 69) begin
      miscompares++;
      $display("FAIL zero_latency: got %0d want 69", lat);
    end
    vectors++;
    if (s !== 32'h0 || z !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_syn: got %h z=%b want 00000000 z=1", s, z);
    end
  endtask

  task automatic test_directed();
    logic [63:0] cws [3];
    logic [31:0] exp [3];
    logic [31:0] s;
    logic        z;
    int          lat, early, bb;
    hmat[0] = 32'h0001_0001;
    hmat[1] = 32'h0;
    hmat[2] = 32'h0;
    hmat[3] = 32'h0;
    cws[0] = 64'h1; exp[0] = 32'h0001_0001;
    cws[1] = 64'h2; exp[1] = 32'h8000_8000;
    cws[2] = 64'h3; exp[2] = 32'h8001_8001;
    for (int k = 0; k < 3; k++) begin
      run_cw(cws[k], 100, 0, s, z, lat, early, bb);
      vectors++;
      if (s !== exp[k] || z !== 1'b0) begin
        miscompares++;
        $display("FAIL directed_%0d: got %h z=%b want %h z=0",
                 k, s, z, exp[k]);
      end
    end
  endtask

  task automatic test_random_gaps();
    logic [63:0] cw;
    logic [31:0] s, e;
    logic        z;
    int          lat, early, bb;
    for (int k = 0; k < 6; k++) begin
      rand_h();
      cw = {$urandom, $urandom};
      e  = ref_syn(cw);
      run_cw(cw, 50, 0, s, z, lat, early, bb);
      vectors++;
      if (s !== e || z !== (e == 0)) begin
        miscompares++;
        $display("FAIL gaps_syn_%0d: got %h z=%b want %h", k, s, z, e);
      end
      vectors++;
      if (early != 0 || lat < 69) begin
        miscompares++;
        $display("FAIL gaps_timing_%0d: got lat=%0d early=%0d want >=69 0",
                 k, lat, early);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [63:0] cw;
    logic [31:0] s, e;
    logic        z;
    int          lat, early, bb;
    rand_h();
    cw = {$urandom, $urandom};
    e  = ref_syn(cw);
    run_cw(cw, 100, 1, s, z, lat, early, bb);
    vectors++;
    if (s !== e || lat !== 69) begin
      miscompares++;
      $display("FAIL start_ignored: got %h lat=%0d want %h lat=69",
               s, lat, e);
    end
    vectors++;
    if (bb != 0) begin
      miscompares++;
      $display("FAIL start_busy: got %0d busy drops want 0", bb);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] cw;
    logic [31:0] s, e;
    logic        z;
    int          lat, early, bb;
    int          bad;
    for (int k = 0; k < 3; k++) begin
      rand_h();
      cw = (k == 1) ? 64'h0 : {$urandom, $urandom};
      e  = ref_syn(cw);
      run_cw(cw, 80, 0, s, z, lat, early, bb);
      vectors++;
      if (s !== e) begin
        miscompares++;
        $display("FAIL b2b_syn_%0d: got %h want %h", k, s, e);
      end
    end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (syn_valid !== 1'b0 || busy !== 1'b0 || syndrome !== e ||
          syn_zero !== (e == 0)) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL hold_idle: %0d bad cycles, syn=%h want %h sv=0 busy=0",
               bad, syndrome, e);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] s;
    logic        z;
    int          lat, early, bb;
    int          acc_n, n;
    bit          a;
    rand_h();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    acc_n = 0; n = 0;
    while (acc_n < 20 && n < 200) begin
      in_bit = 1'($urandom);
      a = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (a) acc_n++;
      n++;
    end
    vectors++;
    if (acc_n != 20 || h_blk_idx !== 2'd1) begin
      miscompares++;
      $display("FAIL abort_pre: got acc=%0d idx=%0d want 20 1",
               acc_n, h_blk_idx);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b0 || syn_valid !== 1'b0 || busy !== 1'b0 ||
        h_blk_idx !== 2'd0 || syndrome !== 32'h0 || syn_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_reset: rdy=%b sv=%b busy=%b idx=%0d syn=%h z=%b want 0 0 0 0 0 1",
               in_ready, syn_valid, busy, h_blk_idx, syndrome, syn_zero);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_cw(64'h0, 100, 0, s, z, lat, early, bb);
    vectors++;
    if (z !== 1'b1 || s !== 32'h0 || lat !== 69) begin
      miscompares++;
      $display("FAIL abort_next: got %h z=%b lat=%0d want 0 1 69", s, z, lat);
    end
  endtask

  initial begin
    start    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    for (int b = 0; b < 4; b++) hmat[b] = '0;
    test_reset();
    test_all_zero();
    test_directed();
    test_random_gaps();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
